// File: rtl/connected_domain_pkg.sv
// Shared constants for the connected-domain filter image store:
// geometry of the 512x512 binary image, access types and arbiter state codes.
package connected_domain_pkg;

  localparam int ADDR_W = 13;
  localparam int ROW_W  = 9;
  localparam int WIDE_W = 512;
  localparam int WORD_W = 32;
  localparam int LANES  = 16;
  localparam int LANE_W = $clog2(LANES);
  localparam int BE_W   = WIDE_W / 8;

  localparam logic ACC_512 = 1'b0;
  localparam logic ACC_32  = 1'b1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_RD_RESP = 2'd2;
  localparam logic [1:0] ST_WR_RESP = 2'd3;

  function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:LANE_W];
  endfunction

  function automatic logic [LANE_W-1:0] lane_of(input logic [ADDR_W-1:0] addr);
    return addr[LANE_W-1:0];
  endfunction

endpackage

// File: rtl/bram_lane_mux.sv
// Lane steering between the 512-bit BRAM row and 32-bit client words:
// zero-extended lane extract for reads, byte enables and replication for writes.
module bram_lane_mux
  import connected_domain_pkg::*;
(
  input  logic              rd_type,
  input  logic [LANE_W-1:0] rd_lane,
  input  logic [WIDE_W-1:0] rd_row,
  output logic [WIDE_W-1:0] rd_data,
  input  logic [LANE_W-1:0] wr_lane,
  input  logic [WORD_W-1:0] wr_word,
  output logic [BE_W-1:0]   wr_be,
  output logic [WIDE_W-1:0] wr_row
);

  always_comb begin
    rd_data = '0;
    if (rd_type == ACC_512) begin
      rd_data = rd_row;
    end else begin
      rd_data[WORD_W-1:0] = rd_row[rd_lane*WORD_W +: WORD_W];
    end
  end

  // Lane 0 occupies the least significant bytes of the row.
  assign wr_be  = {{(BE_W-4){1'b0}}, 4'hF} << {wr_lane, 2'b00};
  assign wr_row = {LANES{wr_word}};

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter putting the boundary-search read client and the masked
// write client onto one BRAM port, with latency tracking for reads.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | no transaction; grant a pending client this cycle
// ST_RD_WAIT | read issued, counting down BRAM latency to the data cycle
// ST_RD_RESP | o_rd_data_valid pulse, read data registered
// ST_WR_RESP | write strobe on the port, o_wr_ack pulse
module bram_port_arbiter
  import connected_domain_pkg::*;
#(
  parameter int RD_LATENCY = 2
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_rd_addr_ready,
  input  logic              i_rd_access_type,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_data_valid,
  output logic [WIDE_W-1:0] o_rd_data,
  input  logic              i_wr_trig,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WORD_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  output logic              o_bram_en,
  output logic [BE_W-1:0]   o_bram_we,
  output logic [ROW_W-1:0]  o_bram_addr,
  output logic [WIDE_W-1:0] o_bram_wdata,
  input  logic [WIDE_W-1:0] i_bram_rdata,
  output logic              o_busy
);

  logic [1:0]        state;
  logic [2:0]        lat_cnt;
  logic              favour_wr;
  logic              rd_type_q;
  logic [LANE_W-1:0] rd_lane_q;
  logic [WIDE_W-1:0] rd_mux;
  logic [BE_W-1:0]   wr_be;
  logic [WIDE_W-1:0] wr_row;
  logic              grant_rd;
  logic              grant_wr;

  bram_lane_mux u_lane_mux (
    .rd_type (rd_type_q),
    .rd_lane (rd_lane_q),
    .rd_row  (i_bram_rdata),
    .rd_data (rd_mux),
    .wr_lane (lane_of(i_wr_addr)),
    .wr_word (i_wr_data),
    .wr_be   (wr_be),
    .wr_row  (wr_row)
  );

  // On a collision the client not granted last wins.
  assign grant_wr = (state == ST_IDLE) && i_wr_trig && (!i_rd_addr_ready || favour_wr);
  assign grant_rd = (state == ST_IDLE) && i_rd_addr_ready && (!i_wr_trig || !favour_wr);
  assign o_busy   = (state != ST_IDLE);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state           <= ST_IDLE;
      lat_cnt         <= '0;
      favour_wr       <= 1'b1;
      rd_type_q       <= ACC_512;
      rd_lane_q       <= '0;
      o_rd_data_valid <= 1'b0;
      o_rd_data       <= '0;
      o_wr_ack        <= 1'b0;
      o_bram_en       <= 1'b0;
      o_bram_we       <= '0;
      o_bram_addr     <= '0;
      o_bram_wdata    <= '0;
    end else begin
      o_bram_en       <= 1'b0;
      o_bram_we       <= '0;
      o_rd_data_valid <= 1'b0;
      o_wr_ack        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_wr) begin
            o_bram_en    <= 1'b1;
            o_bram_we    <= wr_be;
            o_bram_addr  <= row_of(i_wr_addr);
            o_bram_wdata <= wr_row;
            o_wr_ack     <= 1'b1;
            favour_wr    <= 1'b0;
            state        <= ST_WR_RESP;
          end else if (grant_rd) begin
            o_bram_en   <= 1'b1;
            o_bram_addr <= row_of(i_rd_addr);
            rd_type_q   <= i_rd_access_type;
            rd_lane_q   <= lane_of(i_rd_addr);
            lat_cnt     <= 3'(RD_LATENCY);
            favour_wr   <= 1'b1;
            state       <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          // Terminal count marks the cycle the BRAM presents the row.
          if (lat_cnt == 3'd0) begin
            o_rd_data       <= rd_mux;
            o_rd_data_valid <= 1'b1;
            state           <= ST_RD_RESP;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        ST_RD_RESP: state <= ST_IDLE;
        ST_WR_RESP: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: one DUT with a writable BRAM model at
// read latency 2, plus latency-1 and latency-4 instances for timing checks.
module tb_bram_port_arbiter;
  import connected_domain_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn;
  logic         rd_req, rd_type, rd_valid, wr_trig, wr_ack, bram_en, busy;
  logic [12:0]  rd_addr, wr_addr;
  logic [31:0]  wr_data;
  logic [511:0] rd_data, bram_wdata, bram_rdata;
  logic [63:0]  bram_we;
  logic [8:0]   bram_addr;

  logic         rd_req_v1, rd_req_v4, rd_type_v, wr_trig_v;
  logic [12:0]  rd_addr_v, wr_addr_v;
  logic [31:0]  wr_data_v;
  logic         rd_valid_l1, wr_ack_l1, en_l1, busy_l1;
  logic         rd_valid_l4, wr_ack_l4, en_l4, busy_l4;
  logic [511:0] rd_data_l1, wdata_l1, rdata_l1, rd_data_l4, wdata_l4, rdata_l4;
  logic [63:0]  we_l1, we_l4;
  logic [8:0]   addr_l1, addr_l4;

  int n_vec = 0;
  int n_err = 0;

  bram_port_arbiter #(.RD_LATENCY(2)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_rd_addr_ready(rd_req), .i_rd_access_type(rd_type), .i_rd_addr(rd_addr),
    .o_rd_data_valid(rd_valid), .o_rd_data(rd_data),
    .i_wr_trig(wr_trig), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(wr_ack),
    .o_bram_en(bram_en), .o_bram_we(bram_we), .o_bram_addr(bram_addr),
    .o_bram_wdata(bram_wdata), .i_bram_rdata(bram_rdata), .o_busy(busy)
  );

  bram_port_arbiter #(.RD_LATENCY(1)) dut_l1 (
    .i_clk(clk), .i_rstn(rstn),
    .i_rd_addr_ready(rd_req_v1), .i_rd_access_type(rd_type_v), .i_rd_addr(rd_addr_v),
    .o_rd_data_valid(rd_valid_l1), .o_rd_data(rd_data_l1),
    .i_wr_trig(wr_trig_v), .i_wr_addr(wr_addr_v), .i_wr_data(wr_data_v), .o_wr_ack(wr_ack_l1),
    .o_bram_en(en_l1), .o_bram_we(we_l1), .o_bram_addr(addr_l1),
    .o_bram_wdata(wdata_l1), .i_bram_rdata(rdata_l1), .o_busy(busy_l1)
  );

  bram_port_arbiter #(.RD_LATENCY(4)) dut_l4 (
    .i_clk(clk), .i_rstn(rstn),
    .i_rd_addr_ready(rd_req_v4), .i_rd_access_type(rd_type_v), .i_rd_addr(rd_addr_v),
    .o_rd_data_valid(rd_valid_l4), .o_rd_data(rd_data_l4),
    .i_wr_trig(wr_trig_v), .i_wr_addr(wr_addr_v), .i_wr_data(wr_data_v), .o_wr_ack(wr_ack_l4),
    .o_bram_en(en_l4), .o_bram_we(we_l4), .o_bram_addr(addr_l4),
    .o_bram_wdata(wdata_l4), .i_bram_rdata(rdata_l4), .o_busy(busy_l4)
  );

  // Word at (row r, lane k) is {16'(r), 12'hA5C, k}, so every word is unique.
  function automatic logic [511:0] row_pat(input logic [8:0] r);
    logic [511:0] row;
    for (int k = 0; k < 16; k++) row[k*32 +: 32] = {7'd0, r, 12'hA5C, 4'(k)};
    return row;
  endfunction

  function automatic logic [511:0] merge_row(input logic [511:0] old_row,
                                             input logic [511:0] wd, input logic [63:0] be);
    logic [511:0] row;
    row = old_row;
    for (int b = 0; b < 64; b++) if (be[b]) row[b*8 +: 8] = wd[b*8 +: 8];
    return row;
  endfunction

  logic [511:0] mem [512];
  logic [511:0] pipe0, pipe1, p1, p4a, p4b, p4c, p4d;

  always @(posedge clk) begin
    if (!rstn) begin
      for (int r = 0; r < 512; r++) mem[r] <= row_pat(9'(r));
    end else if (bram_en && (|bram_we)) begin
      mem[bram_addr] <= merge_row(mem[bram_addr], bram_wdata, bram_we);
    end
    pipe0 <= bram_en ? mem[bram_addr] : '0;
    pipe1 <= pipe0;
    p1    <= en_l1 ? row_pat(addr_l1) : '0;
    p4a   <= en_l4 ? row_pat(addr_l4) : '0;
    p4b   <= p4a;
    p4c   <= p4b;
    p4d   <= p4c;
  end
  assign bram_rdata = pipe1;
  assign rdata_l1   = p1;
  assign rdata_l4   = p4d;

  // Client protocol watch: requests held stable until their response.
  logic        rd_req_p = 1'b0, wr_trig_p = 1'b0, rd_type_p, proto_bad = 1'b0;
  logic [12:0] rd_addr_p, wr_addr_p;
  logic [31:0] wr_data_p;
  always @(posedge clk) begin
    if (rstn && rd_req_p && ((!rd_req && !rd_valid) ||
        (rd_req && (rd_addr !== rd_addr_p || rd_type !== rd_type_p)))) begin
      proto_bad <= 1'b1;
      $display("FAIL rd_protocol: request dropped or changed while pending at %0t", $time);
    end
    if (rstn && wr_trig_p && ((!wr_trig && !wr_ack) ||
        (wr_trig && (wr_addr !== wr_addr_p || wr_data !== wr_data_p)))) begin
      proto_bad <= 1'b1;
      $display("FAIL wr_protocol: request dropped or changed while pending at %0t", $time);
    end
    rd_req_p  <= rd_req;
    rd_addr_p <= rd_addr;
    rd_type_p <= rd_type;
    wr_trig_p <= wr_trig;
    wr_addr_p <= wr_addr;
    wr_data_p <= wr_data;
  end

  task automatic do_read(input logic [12:0] a, input logic t, output int lat,
                         output logic [511:0] data, output logic [8:0] baddr,
                         output int en_cnt, output bit busy_ok);
    rd_addr = a; rd_type = t; rd_req = 1'b1;
    lat = -1; data = '0; baddr = '0; en_cnt = 0; busy_ok = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) baddr = bram_addr;
      if (bram_en) en_cnt++;
      if (!busy) busy_ok = 1'b0;
      if (rd_valid) begin
        lat = k; data = rd_data; rd_req = 1'b0;
        break;
      end
    end
    rd_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_write(input logic [12:0] a, input logic [31:0] d, output int lat,
                          output logic [63:0] we, output logic [511:0] wd,
                          output logic [8:0] baddr);
    wr_addr = a; wr_data = d; wr_trig = 1'b1;
    lat = -1; we = '0; wd = '0; baddr = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin we = bram_we; wd = bram_wdata; baddr = bram_addr; end
      if (wr_ack) begin
        lat = k; wr_trig = 1'b0;
        break;
      end
    end
    wr_trig = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [512+512+64+9+5-1:0] all_out;
    all_out = {rd_data, bram_wdata, bram_we, bram_addr, rd_valid, wr_ack, bram_en, busy, 1'b0};
    n_vec++;
    if (all_out !== '0) begin
      n_err++; $display("FAIL reset_outputs: got nonzero outputs, expected all 0");
    end
    rstn = 1'b1;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || bram_en !== 1'b0) begin
      n_err++; $display("FAIL idle_after_reset: busy=%b en=%b expected 0 0", busy, bram_en);
    end
  endtask

  task automatic run_collision(input logic [12:0] wa, input logic [31:0] wd,
                               input logic [12:0] ra, output int wr_k, output int rd_k,
                               output logic [511:0] rdat);
    wr_addr = wa; wr_data = wd; wr_trig = 1'b1;
    rd_addr = ra; rd_type = ACC_32; rd_req = 1'b1;
    wr_k = -1; rd_k = -1; rdat = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (wr_ack) begin wr_k = k; wr_trig = 1'b0; end
      if (rd_valid) begin rd_k = k; rdat = rd_data; rd_req = 1'b0; end
      if (!wr_trig && !rd_req) break;
    end
    wr_trig = 1'b0; rd_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_collision();
    int wk, rk, lat, enc;
    logic [511:0] d, wd;
    logic [63:0] we;
    logic [8:0] ba;
    bit bok;
    run_collision(13'h1234, 32'h1357_2468, 13'h0A07, wk, rk, d);
    n_vec++;
    if (wk !== 1 || rk !== 6) begin
      n_err++; $display("FAIL collision1_order: wr_ack@%0d rd_valid@%0d expected 1 6", wk, rk);
    end
    n_vec++;
    if (d !== {480'd0, 32'h00A0_A5C7}) begin
      n_err++; $display("FAIL collision1_rdata: got %h expected 00a0a5c7", d[31:0]);
    end
    do_write(13'h0050, 32'hCAFE_F00D, lat, we, wd, ba);
    n_vec++;
    if (lat !== 1) begin
      n_err++; $display("FAIL lone_write_ack: ack@%0d expected 1", lat);
    end
    run_collision(13'h0051, 32'h0BAD_F00D, 13'h1234, wk, rk, d);
    n_vec++;
    if (rk !== 4 || wk !== 6) begin
      n_err++; $display("FAIL collision2_order: rd_valid@%0d wr_ack@%0d expected 4 6", rk, wk);
    end
    n_vec++;
    if (d !== {480'd0, 32'h1357_2468}) begin
      n_err++; $display("FAIL collision2_rdata: got %h expected 13572468", d[31:0]);
    end
    do_read(13'h0051, ACC_32, lat, d, ba, enc, bok);
    n_vec++;
    if (d !== {480'd0, 32'h0BAD_F00D}) begin
      n_err++; $display("FAIL collision2_wr_landed: got %h expected 0badf00d", d[31:0]);
    end
  endtask

  task automatic test_rd_word();
    int lat, enc;
    logic [511:0] d;
    logic [8:0] ba;
    bit bok;
    do_read(13'h0123, ACC_32, lat, d, ba, enc, bok);
    n_vec++;
    if (ba !== 9'h012 || enc !== 1) begin
      n_err++; $display("FAIL rd_word_port: addr=%h en_cycles=%0d expected 012 1", ba, enc);
    end
    n_vec++;
    if (lat !== 4 || bok !== 1'b1) begin
      n_err++; $display("FAIL rd_word_timing: valid@%0d busy_ok=%b expected 4 1", lat, bok);
    end
    n_vec++;
    if (d !== {480'd0, 32'h0012_A5C3}) begin
      n_err++; $display("FAIL rd_word_data: got %h expected zero-extended 0012a5c3", d);
    end
    n_vec++;
    if (rd_valid !== 1'b0 || rd_data !== {480'd0, 32'h0012_A5C3}) begin
      n_err++; $display("FAIL rd_word_hold: valid=%b data=%h expected 0 0012a5c3", rd_valid, rd_data[31:0]);
    end
  endtask

  task automatic test_rd_row();
    int lat, enc;
    logic [511:0] d;
    logic [8:0] ba;
    bit bok;
    do_read(13'h1FF5, ACC_512, lat, d, ba, enc, bok);
    n_vec++;
    if (ba !== 9'h1FF || lat !== 4) begin
      n_err++; $display("FAIL rd_row_port: addr=%h valid@%0d expected 1ff 4", ba, lat);
    end
    n_vec++;
    if (d !== row_pat(9'h1FF)) begin
      n_err++; $display("FAIL rd_row_data: got %h expected row 1ff", d);
    end
  endtask

  task automatic test_write();
    int lat, enc;
    logic [511:0] wd, d;
    logic [63:0] we;
    logic [8:0] ba;
    bit bok;
    do_write(13'h000F, 32'hDEAD_BEEF, lat, we, wd, ba);
    n_vec++;
    if (we !== 64'hF000_0000_0000_0000 || ba !== 9'h000) begin
      n_err++; $display("FAIL wr_be: we=%h addr=%h expected f000000000000000 000", we, ba);
    end
    n_vec++;
    if (wd[511:480] !== 32'hDEAD_BEEF || wd !== {16{32'hDEAD_BEEF}}) begin
      n_err++; $display("FAIL wr_wdata: top=%h expected deadbeef replicated", wd[511:480]);
    end
    n_vec++;
    if (lat !== 1) begin
      n_err++; $display("FAIL wr_ack_timing: ack@%0d expected 1", lat);
    end
    do_read(13'h000F, ACC_32, lat, d, ba, enc, bok);
    n_vec++;
    if (d !== {480'd0, 32'hDEAD_BEEF}) begin
      n_err++; $display("FAIL wr_readback: got %h expected deadbeef", d[31:0]);
    end
    do_read(13'h000E, ACC_32, lat, d, ba, enc, bok);
    n_vec++;
    if (d !== {480'd0, 32'h0000_A5CE}) begin
      n_err++; $display("FAIL wr_neighbour_intact: got %h expected 0000a5ce", d[31:0]);
    end
  endtask

  task automatic test_reset_mid_read();
    int lat, enc, seen;
    logic [511:0] d;
    logic [8:0] ba;
    bit bok;
    rd_addr = 13'h0042; rd_type = ACC_32; rd_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0; rd_req = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({rd_valid, wr_ack, bram_en, busy} !== 4'b0 || bram_we !== '0 || bram_addr !== '0 ||
        bram_wdata !== '0 || rd_data !== '0) begin
      n_err++; $display("FAIL reset_mid_read_outputs: valid=%b en=%b busy=%b addr=%h expected all 0",
                        rd_valid, bram_en, busy, bram_addr);
    end
    rstn = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rd_valid) seen++;
    end
    n_vec++;
    if (seen !== 0) begin
      n_err++; $display("FAIL reset_discard: %0d stray valid pulses expected 0", seen);
    end
    do_read(13'h0042, ACC_32, lat, d, ba, enc, bok);
    n_vec++;
    if (lat !== 4 || d !== {480'd0, 32'h0004_A5C2}) begin
      n_err++; $display("FAIL post_reset_read: valid@%0d data=%h expected 4 0004a5c2", lat, d[31:0]);
    end
  endtask

  task automatic test_latency_variants();
    int k1, k4;
    bit b1, b4;
    logic [511:0] d1, d4;
    rd_addr_v = 13'h0BC9; rd_type_v = ACC_32; rd_req_v1 = 1'b1; rd_req_v4 = 1'b1;
    k1 = -1; k4 = -1; b1 = 1'b1; b4 = 1'b1; d1 = '0; d4 = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k1 < 0 && !busy_l1) b1 = 1'b0;
      if (k4 < 0 && !busy_l4) b4 = 1'b0;
      if (k1 < 0 && rd_valid_l1) begin k1 = k; d1 = rd_data_l1; rd_req_v1 = 1'b0; end
      if (k4 < 0 && rd_valid_l4) begin k4 = k; d4 = rd_data_l4; rd_req_v4 = 1'b0; end
      if (k1 > 0 && k4 > 0) break;
    end
    rd_req_v1 = 1'b0; rd_req_v4 = 1'b0;
    n_vec++;
    if (k1 !== 3 || b1 !== 1'b1) begin
      n_err++; $display("FAIL lat1_timing: valid@%0d busy_ok=%b expected 3 1", k1, b1);
    end
    n_vec++;
    if (k4 !== 6 || b4 !== 1'b1) begin
      n_err++; $display("FAIL lat4_timing: valid@%0d busy_ok=%b expected 6 1", k4, b4);
    end
    n_vec++;
    if (d1 !== {480'd0, 32'h00BC_A5C9} || d4 !== {480'd0, 32'h00BC_A5C9}) begin
      n_err++; $display("FAIL lat_variant_data: l1=%h l4=%h expected 00bca5c9", d1[31:0], d4[31:0]);
    end
    @(negedge clk);
    n_vec++;
    if (busy_l1 !== 1'b0 || busy_l4 !== 1'b0 || wr_ack_l1 !== 1'b0 || wr_ack_l4 !== 1'b0) begin
      n_err++; $display("FAIL lat_variant_idle: busy %b %b ack %b %b expected 0", busy_l1, busy_l4,
                        wr_ack_l1, wr_ack_l4);
    end
  endtask

  initial begin
    rstn = 1'b0;
    rd_req = 1'b0; rd_type = 1'b0; rd_addr = '0;
    wr_trig = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req_v1 = 1'b0; rd_req_v4 = 1'b0; rd_type_v = 1'b0; rd_addr_v = '0;
    wr_trig_v = 1'b0; wr_addr_v = '0; wr_data_v = '0;
    repeat (4) @(negedge clk);
    test_reset();
    test_collision();
    test_rd_word();
    test_rd_row();
    test_write();
    test_reset_mid_read();
    test_latency_variants();
    n_vec++;
    if (proto_bad !== 1'b0) begin
      n_err++; $display("FAIL client_protocol: violation flag=%b expected 0", proto_bad);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
